pulse_period_meter: RTL and testbench

- Receive-side companion to the team's 555-style astable pulse generator.
- Samples an incoming pulse train in the clk domain and measures the high time and low time of each complete period, in clk cycles.
- Publishes the measurements with a one-cycle valid strobe and flags whether they fall within tolerance of the expected on/off durations.
- Sits downstream of the timer on the lab board; used for self-check and display of the generated waveform.

---
 rtl/pulse_period_meter.sv | 97 +++++++++
 tb/tb_pulse_period_meter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures high/low durations of a pulse train in clk cycles
// and flags periods that fall within tolerance of the expected timer output.
module pulse_period_meter #(
   parameter int CNT_W   = 16,
   parameter int EXP_ON  = 353,
   parameter int EXP_OFF = 346,
   parameter int TOL     = 4,
   parameter int TIMEOUT = 4095
) (
   input  logic             clk,
   input  logic             count_on_rst,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] on_count,
   output logic [CNT_W-1:0] off_count,
   output logic [CNT_W:0]   period_count,
   output logic             valid,
   output logic             match,
   output logic             stuck,
   output logic [7:0]       periods
);
   typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
   localparam logic [CNT_W-1:0] E_ON  = CNT_W'(EXP_ON);
   localparam logic [CNT_W-1:0] E_OFF = CNT_W'(EXP_OFF);
   localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   state_t state, state_n;
   logic s1, s, s_d, rise, fall;
   logic start, publish, timeout, hi_inc, lo_start, lo_inc;
   logic [CNT_W-1:0] hi_cnt, lo_cnt;
   function automatic logic [CNT_W-1:0] adiff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      return a >= b ? a - b : b - a;
   endfunction
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;
   always_ff @(posedge clk or posedge count_on_rst)
      if (count_on_rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n  = state;
      start    = 1'b0;
      publish  = 1'b0;
      timeout  = 1'b0;
      lo_start = 1'b0;
      case (state)
         IDLE: if (rise) begin
            start   = 1'b1;
            state_n = MEAS_HIGH;
         end
         MEAS_HIGH: if (fall) begin
            lo_start = 1'b1;
            state_n  = MEAS_LOW;
         end else if (hi_cnt == TMO) begin
            timeout = 1'b1;
            state_n = IDLE;
         end
         MEAS_LOW: if (rise) begin
            publish = 1'b1;
            state_n = MEAS_HIGH;
         end else if (lo_cnt == TMO) begin
            timeout = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      hi_inc = state == MEAS_HIGH && state_n == MEAS_HIGH;
      lo_inc = state == MEAS_LOW && state_n == MEAS_LOW;
   end
   always_ff @(posedge clk or posedge count_on_rst)
      if (count_on_rst) begin
         {s1, s, s_d} <= 3'b000;
         hi_cnt       <= '0;
         lo_cnt       <= '0;
         on_count     <= '0;
         off_count    <= '0;
         period_count <= '0;
         valid        <= 1'b0;
         match        <= 1'b0;
         stuck        <= 1'b0;
         periods      <= '0;
      end else begin
         s1    <= pulse_in;
         s     <= s1;
         s_d   <= s;
         valid <= publish;
         hi_cnt <= (start || publish) ? ONE : hi_inc ? hi_cnt + ONE : hi_cnt;
         lo_cnt <= lo_start ? ONE : lo_inc ? lo_cnt + ONE : lo_cnt;
         stuck  <= timeout ? 1'b1 : start ? 1'b0 : stuck;
         if (publish) begin
            on_count     <= hi_cnt;
            off_count    <= lo_cnt;
            period_count <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
            match        <= adiff(hi_cnt, E_ON) <= TOL_V && adiff(lo_cnt, E_OFF) <= TOL_V;
            periods      <= periods + 8'd1;
         end
      end
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: table-driven periods with a scoreboard of expected
// measurements, plus timeout, minimum-pulse, reset and wrap sequences.
module tb_pulse_period_meter;
   logic clk = 1'b0;
   logic count_on_rst, pulse_in;
   logic [15:0] on_count, off_count;
   logic [16:0] period_count;
   logic valid, match, stuck;
   logic [7:0] periods;
   typedef struct {int on; int off; int per; logic m;} exp_t;
   typedef struct {int h; int l; logic m;} vec_t;
   exp_t sb[$];
   vec_t tbl[7];
   int n_chk = 0, n_fail = 0, cyc = 0, last_v = -10;
   logic [7:0] exp_periods = 8'd0;

   pulse_period_meter dut (
      .clk(clk), .count_on_rst(count_on_rst), .pulse_in(pulse_in),
      .on_count(on_count), .off_count(off_count), .period_count(period_count),
      .valid(valid), .match(match), .stuck(stuck), .periods(periods)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_on"}, on_count, 0);
      chk({tag, "_off"}, off_count, 0);
      chk({tag, "_per"}, period_count, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_match"}, match, 0);
      chk({tag, "_stuck"}, stuck, 0);
      chk({tag, "_periods"}, periods, 0);
   endtask

   task automatic phase(input logic lv, input int n);
      pulse_in = lv;
      repeat (n) @(negedge clk);
   endtask

   task automatic period(input int h, input int l, input logic m);
      sb.push_back('{h, l, h + l, m});
      phase(1'b1, h);
      phase(1'b0, l);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (count_on_rst) begin
         exp_periods = 8'd0;
         sb.delete();
      end else if (valid) begin
         chk("valid_gap_ge2", (cyc - last_v >= 2) ? 1 : 0, 1);
         last_v = cyc;
         exp_periods = exp_periods + 8'd1;
         chk("periods", periods, exp_periods);
         if (sb.size() == 0) chk("sb_nonempty_at_valid", sb.size(), 1);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("on_count", on_count, e.on);
            chk("off_count", off_count, e.off);
            chk("period_count", period_count, e.per);
            chk("match", match, e.m);
         end
      end
   end

   initial begin
      tbl[0] = '{353, 346, 1'b1};
      tbl[1] = '{357, 342, 1'b1};
      tbl[2] = '{349, 350, 1'b1};
      tbl[3] = '{358, 346, 1'b0};
      tbl[4] = '{353, 351, 1'b0};
      tbl[5] = '{348, 346, 1'b0};
      tbl[6] = '{1, 1, 1'b0};
      count_on_rst = 1'b1;
      pulse_in = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      count_on_rst = 1'b0;
      phase(1'b0, 5);
      // three nominal periods: only the first two are closed by a following rise
      for (int i = 0; i < 3; i++) period(353, 346, 1'b1);
      chk("nominal_periods", periods, 2);
      foreach (tbl[i]) period(tbl[i].h, tbl[i].l, tbl[i].m);
      // held high: hi_cnt hits 4095 and times out on the following cycle
      period(353, 346, 1'b1);
      pulse_in = 1'b1;
      repeat (4097) @(negedge clk);
      chk("stuck_before_timeout", stuck, 0);
      @(negedge clk);
      chk("stuck_set", stuck, 1);
      chk("on_count_hold", on_count, 353);
      chk("match_hold", match, 1);
      repeat (5000 - 4098) @(negedge clk);
      chk("stuck_held", stuck, 1);
      phase(1'b0, 10);
      period(355, 344, 1'b1);
      chk("stuck_cleared", stuck, 0);
      for (int i = 0; i < 6; i++) period(1, 1, 1'b0);
      // reset in the middle of a low phase
      phase(1'b1, 353);
      phase(1'b0, 100);
      count_on_rst = 1'b1;
      #1;
      chk_zero("midrst");
      repeat (2) @(negedge clk);
      count_on_rst = 1'b0;
      phase(1'b0, 20);
      chk("midrst_no_valid_yet", periods, 0);
      period(353, 346, 1'b1);
      phase(1'b1, 5);
      phase(1'b0, 5);
      chk("midrst_drained", sb.size(), 0);
      chk("midrst_periods", periods, 1);
      count_on_rst = 1'b1;
      repeat (2) @(negedge clk);
      count_on_rst = 1'b0;
      phase(1'b0, 5);
      for (int i = 0; i < 256; i++) period(5, 5, 1'b0);
      phase(1'b1, 5);
      phase(1'b0, 3);
      chk("periods_wrap", periods, 0);
      chk("final_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
